// File: rtl/mux_stream.sv
// Registered valid/ready N-to-1 multiplexer.
// The channel is chosen by an explicit select or by round-robin over the valid channels.
module mux_stream #(
  parameter int SIZE_CTRL = 2,
  parameter int WIRE      = 8,
  localparam int NB_IN    = 2**SIZE_CTRL,
  localparam int SIZE_IN  = NB_IN*WIRE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [SIZE_CTRL-1:0] ctrl,
  input  logic [SIZE_IN-1:0]   in,
  input  logic [NB_IN-1:0]     in_valid,
  output logic [NB_IN-1:0]     in_ready,
  output logic [WIRE-1:0]      out,
  output logic [SIZE_CTRL-1:0] out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [SIZE_CTRL-1:0] PTR_ONE = 1;

  logic [WIRE-1:0]      out_reg;
  logic [SIZE_CTRL-1:0] out_sel_reg;
  logic                 out_valid_reg;
  logic [SIZE_CTRL-1:0] rr_ptr_reg;

  logic [WIRE-1:0]      chan [NB_IN];
  logic [SIZE_CTRL-1:0] rot_idx [NB_IN];
  logic [NB_IN-1:0]     rot_valid;

  logic                 load_ok;
  logic [SIZE_CTRL-1:0] rr_off;
  logic                 rr_found;
  logic [SIZE_CTRL-1:0] rr_grant;
  logic [SIZE_CTRL-1:0] grant;
  logic                 grant_any;
  logic                 accept;

  // rot_valid[k] is the valid of the channel k places above rr_ptr, so the search becomes a plain priority encode
  for (genvar gi = 0; gi < NB_IN; gi++) begin : g_chan
    assign chan[gi]      = in[gi*WIRE +: WIRE];
    assign rot_idx[gi]   = rr_ptr_reg + SIZE_CTRL'(gi);
    assign rot_valid[gi] = in_valid[rot_idx[gi]];
  end

  assign load_ok = !out_valid_reg | out_ready;

  always_comb begin
    rr_off   = '0;
    rr_found = 1'b0;
    for (int k = NB_IN-1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        rr_off   = k[SIZE_CTRL-1:0];
        rr_found = 1'b1;
      end
    end
    rr_grant = rr_ptr_reg + rr_off;
  end

  always_comb begin
    grant     = ctrl;
    grant_any = 1'b1;
    if (mode) begin
      grant     = rr_grant;
      grant_any = rr_found;
    end
  end

  always_comb begin
    in_ready = '0;
    if (!reset && load_ok && grant_any) begin
      in_ready[grant] = 1'b1;
    end
  end

  assign accept = |(in_ready & in_valid);

  // Accept takes priority over drain so a simultaneous drain and reload leaves no bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg       <= '0;
      out_sel_reg   <= '0;
      out_valid_reg <= 1'b0;
      rr_ptr_reg    <= '0;
    end else if (accept) begin
      out_reg       <= chan[grant];
      out_sel_reg   <= grant;
      out_valid_reg <= 1'b1;
      if (mode) begin
        rr_ptr_reg <= grant + PTR_ONE;
      end
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out       = out_reg;
  assign out_sel   = out_sel_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_stream.sv
// Directed bench for mux_stream: reset, fixed select, round-robin, sparse wrap, backpressure,
// reset mid-stream and mode switch, drain. Expected values are hand-computed constants.
module tb_mux_stream;

  logic        clk;
  logic        reset;
  logic        mode;
  logic [1:0]  ctrl;
  logic [31:0] in_bus;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  logic [7:0] data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  mux_stream #(.SIZE_CTRL(2), .WIRE(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .ctrl     (ctrl),
    .in       (in_bus),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] exp_data, input logic [1:0] exp_sel);
    check_val({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_val({tag, ".out"}, 32'(out), 32'(exp_data));
    check_val({tag, ".sel"}, 32'(out_sel), 32'(exp_sel));
  endtask

  initial begin
    reset     = 1'b1;
    mode      = 1'b0;
    ctrl      = 2'd0;
    in_bus    = 32'h44332211;
    in_valid  = 4'hF;
    out_ready = 1'b1;

    // Reset held for two edges with all channels valid
    for (int c = 0; c < 2; c++) begin
      step();
      check_val("rst.valid", 32'(out_valid), 32'd0);
      check_val("rst.out", 32'(out), 32'd0);
      check_val("rst.sel", 32'(out_sel), 32'd0);
      check_val("rst.in_ready", 32'(in_ready), 32'd0);
    end
    reset = 1'b0;

    // Fixed select sweep, first accept on the first cycle after release
    for (int k = 0; k < 4; k++) begin
      ctrl = 2'(k);
      #1;
      check_val("fix.in_ready", 32'(in_ready), 32'(1 << k));
      step();
      check_out("fix", data[k], 2'(k));
    end

    // Round-robin over all channels
    mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check_val("rr.in_ready", 32'(in_ready), 32'(1 << (k % 4)));
      step();
      check_out("rr", data[k % 4], 2'(k % 4));
    end

    // Drive rr_ptr to 3, then only channels 0 and 2 valid
    for (int k = 0; k < 3; k++) begin
      step();
      check_out("pre", data[k], 2'(k));
    end
    in_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_val("sparse.in_ready", 32'(in_ready), (k % 2 == 0) ? 32'h1 : 32'h4);
      step();
      check_out("sparse", (k % 2 == 0) ? 8'h11 : 8'h33, (k % 2 == 0) ? 2'd0 : 2'd2);
    end

    // rr_ptr is 3: grants 3,0,1 bring out to 22
    in_valid = 4'hF;
    step(); check_out("bp.pre3", 8'h44, 2'd3);
    step(); check_out("bp.pre0", 8'h11, 2'd0);
    step(); check_out("bp.pre1", 8'h22, 2'd1);
    out_ready = 1'b0;
    #1;
    check_val("bp.in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check_out("bp.hold", 8'h22, 2'd1);
      check_val("bp.in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check_val("bp.resume.in_ready", 32'(in_ready), 32'h4);
    step();
    check_out("bp.resume", 8'h33, 2'd2);

    // Reset mid-stream: held word discarded, round-robin restarts at 0
    reset = 1'b1;
    #1;
    check_val("mid.in_ready", 32'(in_ready), 32'd0);
    step();
    check_val("mid.valid", 32'(out_valid), 32'd0);
    check_val("mid.out", 32'(out), 32'd0);
    reset = 1'b0;
    #1;
    check_val("mid.restart.in_ready", 32'(in_ready), 32'h1);
    step();
    check_out("mid.restart", 8'h11, 2'd0);

    // Mode 0 accepts must not move rr_ptr (left at 1)
    mode = 1'b0;
    ctrl = 2'd2;
    for (int c = 0; c < 2; c++) begin
      #1;
      check_val("sw.in_ready", 32'(in_ready), 32'h4);
      step();
      check_out("sw", 8'h33, 2'd2);
    end
    mode = 1'b1;
    #1;
    check_val("sw.rr.in_ready", 32'(in_ready), 32'h2);
    step();
    check_out("sw.rr", 8'h22, 2'd1);

    // Drain with nothing valid: out_valid drops, data and sel held
    in_valid = 4'h0;
    #1;
    check_val("drain.in_ready", 32'(in_ready), 32'd0);
    step();
    check_val("drain.valid", 32'(out_valid), 32'd0);
    check_val("drain.out", 32'(out), 32'h22);
    check_val("drain.sel", 32'(out_sel), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_stream.md
# mux_stream

Registered, handshaked N-to-1 multiplexer: the sequential successor of the combinational `mux` in `src/routing`. It selects one of `2**SIZE_CTRL` input channels of `WIRE` bits, either by an explicit select or by round-robin arbitration. It moves one word per cycle through a single output register with valid/ready flow control. It sits between producer blocks and a shared consumer in the routing layer.

## Interface
- `SIZE_CTRL`, default 2: select width; number of channels `NB_IN = 2**SIZE_CTRL`.
- `WIRE`, default 8: data width per channel; flat input width `SIZE_IN = NB_IN*WIRE`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mode`  in  1  0 = fixed select by `ctrl`; 1 = round-robin over valid channels.
- `ctrl`  in  SIZE_CTRL  channel select, used only when `mode=0`.
- `in`  in  SIZE_IN  flat data bus; channel k occupies `in[k*WIRE +: WIRE]`.
- `in_valid`  in  NB_IN  per-channel valid.
- `in_ready`  out  NB_IN  per-channel ready; combinational, at most one bit set (one-hot or zero).
- `out`  out  WIRE  registered output data.
- `out_sel`  out  SIZE_CTRL  registered index of the channel that supplied `out`.
- `out_valid`  out  1  registered output valid.
- `out_ready`  in  1  consumer ready.

## Operation
- Output register states: EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
- `load_ok = !out_valid | out_ready`. A grant is issued only when `load_ok=1`.
- Grant in mode 0: `g = ctrl`. `in_ready[g] = load_ok`, regardless of `in_valid[g]`.
- Grant in mode 1: `g` is the first channel with `in_valid` set, searching from `rr_ptr` upward with wrap (`NB_IN-1` wraps to 0). `in_ready[g] = load_ok`. If no channel is valid, `in_ready` is all zero.
- Accept: `in_valid[g] & in_ready[g]`. On the next edge, `out <= in[g*WIRE +: WIRE]`, `out_sel <= g` and `out_valid <= 1`.
- Drain without accept: on `out_valid & out_ready`, `out_valid <= 0`. `out` and `out_sel` keep their last values.
- Simultaneous drain and accept in the same cycle: the register reloads and `out_valid` stays 1. No bubble occurs.
- Backpressure: while `out_valid & !out_ready`, `out`, `out_sel` and `out_valid` are held stable and `in_ready` is all zero.
- Round-robin pointer: `rr_ptr` is internal, SIZE_CTRL bits. On every accept in mode 1, `rr_ptr <= g+1` (mod NB_IN). Accepts in mode 0 leave `rr_ptr` unchanged.
- `mode` and `ctrl` are sampled combinationally each cycle. A change affects only the next grant, never a word already in the output register.
- Data path arithmetic is pure selection; there is no width conversion.

## Timing
- Reset, synchronous: `out_valid=0`, `out=0`, `out_sel=0`, `rr_ptr=0`. `in_ready` is 0 while `reset=1`.
- Reset mid-transfer: a held word is discarded and no accept happens in the reset cycle.
- Latency: 1 cycle from accept edge to `out_valid`/`out`.
- Throughput: 1 word/cycle when `out_ready=1` continuously.
- Fairness in mode 1: with all channels valid and `out_ready=1`, grants follow 0,1,…,NB_IN-1,0,…
- Wrap: with `rr_ptr=NB_IN-1` and only channel 0 valid, channel 0 is granted and `rr_ptr` becomes 1.
- There is no combinational path from `in` to `out`. `in_ready` depends combinationally on `out_ready`, `out_valid`, `mode`, `ctrl`, `in_valid` and `rr_ptr`.

## Test plan
All scenarios use SIZE_CTRL=2 and WIRE=8, with channel data `8'h11`, `8'h22`, `8'h33`, `8'h44`.
- **Reset:** hold `reset` 2 cycles with all `in_valid=1` -> `out_valid=0`, `out=0`, `out_sel=0` and `in_ready=0` throughout. The first accept occurs on the first cycle after `reset` is released.
- **Fixed select sweep:** mode 0, `out_ready=1`, all valid, `ctrl` = 0,1,2,3 on successive cycles -> one cycle later `out` = 11,22,33,44 and `out_sel` = 0,1,2,3, with `out_valid` continuously 1.
- **Round-robin order:** mode 1, all valid, `out_ready=1`, 8 cycles -> `out` sequence is 11,22,33,44,11,22,33,44 and exactly one `in_ready` bit is set per cycle.
- **Sparse and wrap:** mode 1, `rr_ptr` driven to 3 by prior traffic, then only channels 0 and 2 valid -> grants alternate 0,2,0,2 and channel 3 is never granted.
- **Backpressure:** mode 1, all valid, drop `out_ready` for 3 cycles while `out=8'h22` -> `out` holds 22, `in_ready=0` and no channel is consumed. When `out_ready` returns, the next `out` is 33 and nothing is lost or duplicated.
- **Reset mid-stream and mode switch:** stream in mode 1 and assert `reset` for 1 cycle while `out_valid=1` -> `out_valid=0` next cycle and the round-robin restarts from channel 0. Then switch to mode 0 with `ctrl=2` -> only 33 is output, and `rr_ptr` is unchanged by these accepts.
